// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit owning the HI/LO registers
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign-fixed in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_q, neg_r, divz;

  logic               op_mul, op_div, op_signed, op_mthi, op_mtlo;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   quo, rem, fix_q, fix_r;

  always_comb begin
    op_mul    = (funct == 6'b011000) || (funct == 6'b011001);
    op_div    = (funct == 6'b011010) || (funct == 6'b011011);
    op_signed = (funct == 6'b011000) || (funct == 6'b011010);
    op_mthi   = (funct == 6'b010001);
    op_mtlo   = (funct == 6'b010011);
    abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    fix_prod  = neg_q ? -acc : acc;
    quo       = acc[WIDTH-1:0];
    rem       = acc[2*WIDTH-1:WIDTH];
    fix_q     = divz ? '1 : (neg_q ? -quo : quo);
    fix_r     = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_mthi) hi <= a;
            if (op_mtlo) lo <= a;
            if (op_mul || op_div) begin
              state  <= RUN;
              busy   <= 1'b1;
              count  <= CW'(WIDTH);
              is_div <= op_div;
              neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= op_signed && a[WIDTH-1];
              divz   <= op_div && (b == '0);
              opnd   <= op_div ? abs_b : abs_a;
              acc    <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            if (is_div) begin
              if (!div_diff[WIDTH])
                acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
              else
                acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
          // flush wins over the result write
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= fix_r;
              lo <= fix_q;
            end else begin
              hi <= fix_prod[2*WIDTH-1:WIDTH];
              lo <= fix_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
// Drives WIDTH=32 and WIDTH=8 instances with hand-computed vectors.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush, busy, done;
  logic [5:0]  funct;
  logic [31:0] a, b, hi, lo;
  logic        start8, flush8, busy8, done8;
  logic [5:0]  funct8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .funct(funct8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0; funct = 6'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [5:0] f, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(f, x, y);
    wait_idle(n);
    chk({tag, " busy_cycles"}, n, 32'd33);
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    @(negedge clk);
    chk({tag, " done_drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct = 6'b0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; funct8 = 6'b0; a8 = '0; b8 = '0;

    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(F_MTHI, 32'h11112222, 32'h0);
    chk("mthi hi", hi, 32'h11112222);
    chk("mthi busy", {31'b0, busy}, 32'd0);
    chk("mthi done", {31'b0, done}, 32'd0);
    issue(F_MTLO, 32'h33334444, 32'h55556666);
    chk("mtlo lo", lo, 32'h33334444);
    chk("mtlo hi", hi, 32'h11112222);

    issue(F_ADD, 32'h99999999, 32'h88888888);
    chk("bad funct hi", hi, 32'h11112222);
    chk("bad funct lo", lo, 32'h33334444);
    chk("bad funct busy", {31'b0, busy}, 32'd0);

    run("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("div neg", F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu zero", F_DIVU, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);
    run("div ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // starts during a MULT are ignored; MTLO in the done cycle is accepted
    issue(F_MULT, 32'hFFFFFFFD, 32'h00000005);
    repeat (3) @(negedge clk);
    start = 1'b1; funct = F_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    funct = F_MTHI; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; funct = 6'b0;
    wait_idle(n);
    chk("mult busy_remaining", n, 32'd28);
    chk("mult done", {31'b0, done}, 32'd1);
    chk("mult hi", hi, 32'hFFFFFFFF);
    chk("mult lo", lo, 32'hFFFFFFF1);
    start = 1'b1; funct = F_MTLO; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0; funct = 6'b0;
    chk("b2b mtlo lo", lo, 32'hCAFEF00D);
    chk("b2b mtlo hi", hi, 32'hFFFFFFFF);
    chk("b2b done drop", {31'b0, done}, 32'd0);
    chk("b2b busy", {31'b0, busy}, 32'd0);

    issue(F_MULTU, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    chk("flush hi", hi, 32'hFFFFFFFF);
    chk("flush lo", lo, 32'hCAFEF00D);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("flush no late activity", seen, 32'd0);
    chk("flush lo kept", lo, 32'hCAFEF00D);

    @(negedge clk);
    start8 = 1'b1; funct8 = F_DIVU; a8 = 8'hC8; b8 = 8'h07;
    @(negedge clk);
    start8 = 1'b0; funct8 = 6'b0;
    n = 0;
    while (busy8 === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("w8 busy_cycles", n, 32'd9);
    chk("w8 done", {31'b0, done8}, 32'd1);
    chk("w8 lo", {24'b0, lo8}, 32'h1C);
    chk("w8 hi", {24'b0, hi8}, 32'h04);

    issue(F_DIV, 32'd100, 32'd3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("postreset done", {31'b0, done}, 32'd0);
    chk("postreset lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
